// File: rtl/add_sat_tree_pipe.sv
// Pipelined saturating adder tree: sums NUM_TAPS signed samples, clamping at every node,
// with optional register banks between levels, global-stall flow control and a saturation counter.
module add_sat_tree_pipe #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_TAPS   = 4,
    parameter int PIPE_EVERY = 1,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] in_data [NUM_TAPS],
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat,
    output logic [CNT_WIDTH-1:0]         sat_cnt,
    input  logic                         cnt_clr
);

    localparam int D   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 0;
    localparam int P   = 1 << D;
    localparam int PE  = (PIPE_EVERY > 0) ? PIPE_EVERY : 1;
    localparam int LAT = (PIPE_EVERY > 0) ? (D / PE) : 0;

    // Returns {overflow, clamped sum} of two DATA_WIDTH-bit signed operands.
    function automatic logic [DATA_WIDTH:0] sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] sum_s;
        logic [DATA_WIDTH:0] res_s;
        sum_s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (sum_s[DATA_WIDTH] != sum_s[DATA_WIDTH-1]) begin
            res_s = {1'b1, (sum_s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                              : {1'b0, {(DATA_WIDTH-1){1'b1}}})};
        end else begin
            res_s = {1'b0, sum_s[DATA_WIDTH-1:0]};
        end
        return res_s;
    endfunction

    logic                 advance_s;
    logic [CNT_WIDTH-1:0] sat_cnt_r;

    assign advance_s = out_ready | ~out_valid;

    // Each level exposes q_s/sat_s/vld_s: registered when a bank follows it, else pass-through.
    for (genvar l = 0; l <= D; l++) begin : g_lvl
        localparam int N = P >> l;
        logic signed [DATA_WIDTH-1:0] q_s [N];
        logic                         sat_s;
        logic                         vld_s;

        if (l == 0) begin : g_in
            for (genvar j = 0; j < N; j++) begin : g_pad
                if (j < NUM_TAPS) begin : g_tap
                    assign q_s[j] = in_data[j];
                end else begin : g_zero
                    assign q_s[j] = '0;
                end
            end
            assign sat_s = 1'b0;
            assign vld_s = in_valid;
        end else begin : g_node
            logic signed [DATA_WIDTH-1:0] sum_s [N];
            logic [N-1:0]                 flag_s;
            logic                         sat_in_s;

            for (genvar j = 0; j < N; j++) begin : g_add
                logic [DATA_WIDTH:0] r_s;
                assign r_s       = sat_add(g_lvl[l-1].q_s[2*j], g_lvl[l-1].q_s[2*j+1]);
                assign sum_s[j]  = r_s[DATA_WIDTH-1:0];
                assign flag_s[j] = r_s[DATA_WIDTH];
            end
            assign sat_in_s = g_lvl[l-1].sat_s | (|flag_s);

            if ((PIPE_EVERY > 0) && ((l % PE) == 0)) begin : g_reg
                logic signed [DATA_WIDTH-1:0] q_r [N];
                logic                         sat_r;
                logic                         vld_r;

                // Register bank: loads only on a global advance, holds while stalled.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int k = 0; k < N; k++) q_r[k] <= '0;
                        sat_r <= 1'b0;
                        vld_r <= 1'b0;
                    end else if (advance_s) begin
                        for (int k = 0; k < N; k++) q_r[k] <= sum_s[k];
                        sat_r <= sat_in_s;
                        vld_r <= g_lvl[l-1].vld_s;
                    end
                end

                assign q_s   = q_r;
                assign sat_s = sat_r;
                assign vld_s = vld_r;
            end else begin : g_comb
                assign q_s   = sum_s;
                assign sat_s = sat_in_s;
                assign vld_s = g_lvl[l-1].vld_s;
            end
        end
    end

    assign out_data  = g_lvl[D].q_s[0];
    assign out_sat   = g_lvl[D].sat_s;
    assign out_valid = g_lvl[D].vld_s;
    assign in_ready  = (LAT == 0) ? out_ready : advance_s;

    // Sticky count of delivered saturated beats; clear has priority, count stops at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_r <= '0;
        end else if (cnt_clr) begin
            sat_cnt_r <= '0;
        end else if (out_valid && out_ready && out_sat && !(&sat_cnt_r)) begin
            sat_cnt_r <= sat_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign sat_cnt = sat_cnt_r;

endmodule

// File: tb/tb_add_sat_tree_pipe.sv
// Directed bench for add_sat_tree_pipe: four configurations, scoreboard on the main instance.
module tb_add_sat_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DW6, 4 taps, bank after every level, 8-bit counter
    logic signed [5:0] a_in [4];
    logic a_ivld, a_irdy, a_ovld, a_ordy, a_osat, a_clr;
    logic signed [5:0] a_odata;
    logic [7:0] a_cnt;
    // Instance B: 3 taps
    logic signed [5:0] b_in [3];
    logic b_ivld, b_irdy, b_ovld, b_ordy, b_osat;
    logic signed [5:0] b_odata;
    logic [7:0] b_cnt;
    // Instance C: 2-bit counter
    logic signed [5:0] c_in [4];
    logic c_ivld, c_irdy, c_ovld, c_ordy, c_osat, c_clr;
    logic signed [5:0] c_odata;
    logic [1:0] c_cnt;
    // Instance D: fully combinational
    logic signed [5:0] d_in [4];
    logic d_ivld, d_irdy, d_ovld, d_ordy, d_osat;
    logic signed [5:0] d_odata;
    logic [7:0] d_cnt;

    add_sat_tree_pipe #(.DATA_WIDTH(6), .NUM_TAPS(4), .PIPE_EVERY(1), .CNT_WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .in_data(a_in), .in_valid(a_ivld), .in_ready(a_irdy),
        .out_data(a_odata), .out_valid(a_ovld), .out_ready(a_ordy), .out_sat(a_osat),
        .sat_cnt(a_cnt), .cnt_clr(a_clr));
    add_sat_tree_pipe #(.DATA_WIDTH(6), .NUM_TAPS(3), .PIPE_EVERY(1), .CNT_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .in_data(b_in), .in_valid(b_ivld), .in_ready(b_irdy),
        .out_data(b_odata), .out_valid(b_ovld), .out_ready(b_ordy), .out_sat(b_osat),
        .sat_cnt(b_cnt), .cnt_clr(1'b0));
    add_sat_tree_pipe #(.DATA_WIDTH(6), .NUM_TAPS(4), .PIPE_EVERY(1), .CNT_WIDTH(2)) u_c (
        .clk(clk), .rst(rst), .in_data(c_in), .in_valid(c_ivld), .in_ready(c_irdy),
        .out_data(c_odata), .out_valid(c_ovld), .out_ready(c_ordy), .out_sat(c_osat),
        .sat_cnt(c_cnt), .cnt_clr(c_clr));
    add_sat_tree_pipe #(.DATA_WIDTH(6), .NUM_TAPS(4), .PIPE_EVERY(0), .CNT_WIDTH(8)) u_d (
        .clk(clk), .rst(rst), .in_data(d_in), .in_valid(d_ivld), .in_ready(d_irdy),
        .out_data(d_odata), .out_valid(d_ovld), .out_ready(d_ordy), .out_sat(d_osat),
        .sat_cnt(d_cnt), .cnt_clr(1'b0));

    int n_assert = 0;
    int n_fail   = 0;
    int n_deliv  = 0;
    int a_v [4];
    logic [6:0] exp_q [$];
    logic a_acc, a_stall;
    logic signed [5:0] a_prev;

    // Reference: pad to 4, clamp each pairwise sum to [-32,31]; returns {sat, data}.
    function automatic logic [6:0] model(input int v0, input int v1, input int v2, input int v3);
        int   t [4];
        logic f;
        f = 1'b0;
        t = '{v0, v1, v2, v3};
        for (int n = 4; n > 1; n = n / 2) begin
            for (int j = 0; j < n / 2; j++) begin
                int s;
                s = t[2*j] + t[2*j+1];
                if (s > 31) begin s = 31; f = 1'b1; end
                else if (s < -32) begin s = -32; f = 1'b1; end
                t[j] = s;
            end
        end
        return {f, t[0][5:0]};
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic set_a(input int v0, input int v1, input int v2, input int v3, input logic vld);
        a_v = '{v0, v1, v2, v3};
        for (int i = 0; i < 4; i++) a_in[i] = 6'(a_v[i]);
        a_ivld = vld;
    endtask

    // One clock: settle, run instance-A scoreboard, then advance to just after the next edge.
    task automatic step();
        logic [6:0] e;
        #1;
        a_acc   = a_ivld && a_irdy;
        a_stall = a_ovld && !a_ordy;
        a_prev  = a_odata;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (a_ovld && a_ordy) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_unexpected observed=%0d expected=none", a_odata);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_data", a_odata, $signed(e[5:0]));
                    chk("sb_sat", a_osat, e[6]);
                    n_deliv++;
                end
            end
            if (a_acc) exp_q.push_back(model(a_v[0], a_v[1], a_v[2], a_v[3]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] e;
        int k, c, start, stalls;
        rst = 1'b1;
        set_a(0, 0, 0, 0, 1'b1);
        a_ordy = 1'b1; a_clr = 1'b0;
        for (int i = 0; i < 3; i++) b_in[i] = 6'sd0;
        for (int i = 0; i < 4; i++) begin c_in[i] = 6'sd0; d_in[i] = 6'sd0; end
        b_ivld = 1'b0; b_ordy = 1'b1;
        c_ivld = 1'b0; c_ordy = 1'b1; c_clr = 1'b0;
        d_ivld = 1'b0; d_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", a_ovld, 0);
        chk("rst_out_data", a_odata, 0);
        chk("rst_out_sat", a_osat, 0);
        chk("rst_in_ready", a_irdy, 1);
        chk("rst_sat_cnt", a_cnt, 0);
        rst = 1'b0;
        set_a(0, 0, 0, 0, 1'b0);

        // Basic sum with latency 2
        set_a(10, 5, -3, 7, 1'b1);
        step();
        set_a(0, 0, 0, 0, 1'b0);
        chk("t1_cycle1_valid", a_ovld, 0);
        step();
        chk("t1_cycle2_valid", a_ovld, 1);
        chk("t1_data", a_odata, 19);
        chk("t1_sat", a_osat, 0);
        step();

        // Per-node clamp
        set_a(20, 20, -20, -20, 1'b1);
        step();
        set_a(0, 0, 0, 0, 1'b0);
        step();
        chk("t2_data", a_odata, -1);
        chk("t2_sat", a_osat, 1);
        step();
        chk("t2_sat_cnt", a_cnt, 1);

        // Three taps with zero padding
        b_in = '{6'sd31, 6'sd31, -6'sd32};
        b_ivld = 1'b1;
        step();
        b_ivld = 1'b0;
        step();
        e = model(31, 31, -32, 0);
        chk("t3_valid", b_ovld, 1);
        chk("t3_data", b_odata, $signed(e[5:0]));
        chk("t3_sat", b_osat, e[6]);
        chk("t3_data_lit", b_odata, -1);

        // Backpressure stream k=1..6, out_ready low during cycles 3..5
        k = 1; c = 0; stalls = 0; start = n_deliv;
        while ((k <= 6 || exp_q.size() != 0) && c < 40) begin
            a_ordy = !(c >= 3 && c <= 5);
            if (k <= 6) set_a(k, 0, 0, 0, 1'b1);
            else        set_a(0, 0, 0, 0, 1'b0);
            step();
            if (a_stall) begin
                stalls++;
                chk("bp_hold_data", a_odata, a_prev);
                chk("bp_in_ready_low", a_irdy, 0);
            end
            if (a_acc) k++;
            c++;
        end
        set_a(0, 0, 0, 0, 1'b0);
        a_ordy = 1'b1;
        chk("bp_delivered", n_deliv - start, 6);
        chk("bp_queue_empty", exp_q.size(), 0);
        chk("bp_stall_seen", stalls > 0, 1);

        // Counter saturation with 2-bit width, then clear against a saturating delivery
        c_in = '{6'sd20, 6'sd20, -6'sd20, -6'sd20};
        for (int i = 0; i < 5; i++) begin
            c_ivld = 1'b1;
            step();
            c_ivld = 1'b0;
            step();
            step();
            chk("cnt_value", c_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        c_ivld = 1'b1;
        step();
        c_ivld = 1'b0;
        step();
        chk("clr_beat_valid", c_ovld, 1);
        chk("clr_beat_sat", c_osat, 1);
        c_clr = 1'b1;
        step();
        c_clr = 1'b0;
        chk("clr_wins", c_cnt, 0);

        // Reset with two samples in flight
        a_ordy = 1'b0;
        set_a(9, 0, 0, 0, 1'b1);
        step();
        set_a(12, 0, 0, 0, 1'b1);
        step();
        chk("pre_rst_valid", a_ovld, 1);
        rst = 1'b1;
        set_a(3, 0, 0, 0, 1'b1);
        step();
        chk("mid_rst_valid", a_ovld, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_in_ready", a_irdy, 1);
        chk("mid_rst_data", a_odata, 0);
        chk("mid_rst_sat", a_osat, 0);
        rst = 1'b0;
        set_a(0, 0, 0, 0, 1'b0);
        a_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_ghost", a_ovld, 0);
        end

        // Combinational configuration
        d_in = '{6'sd10, 6'sd5, -6'sd3, 6'sd7};
        d_ivld = 1'b1;
        d_ordy = 1'b1;
        #1;
        chk("comb_valid", d_ovld, 1);
        chk("comb_data", d_odata, 19);
        chk("comb_sat", d_osat, 0);
        chk("comb_in_ready_hi", d_irdy, 1);
        d_ordy = 1'b0;
        #1;
        chk("comb_in_ready_lo", d_irdy, 0);
        d_ivld = 1'b0;
        d_ordy = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
